// File: rtl/mmio_tx_responder.sv
// mmio_tx_responder: CPU-mapped TX FIFO plus STATUS/CTRL/CYCLE registers, drained over a valid/ready stream.
// Latency: register reads are combinational; a stored word can be offered on tx_data the cycle after the store.
// Backpressure: tx_data holds while tx_ready=0; a store to a full FIFO without a same-cycle pop is dropped and sets ovf.
// Optional build macro MMIO_IRQ_EN adds the irq output, STATUS.irqf and CTRL.ie.
module mmio_tx_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`ifdef MMIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_STAT = 2'd1;
    localparam logic [1:0] OFF_CYC  = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    // FIFO storage and bookkeeping
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;

    // Control/status state
    logic          en;
    logic          en_d;
    logic          ovf;
    logic          ovf_d;
    logic          ie;
    logic          irqf;
    logic [31:0]   cycle_q;

    // Bus decode
    logic [1:0]    reg_off;
    logic          bus_wr;
    logic          stat_wr;
    logic          cyc_wr;
    logic          ctrl_wr;

    // FIFO handshake events
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;

    logic [7:0]    count8;
    logic [31:0]   rd_word;

    // Low address bits and the window's own offset bits carry no meaning here.
    logic          unused_bits;
    assign unused_bits = ^{DataAdr[1:0], BASE_ADDR[3:0]};

    assign sel      = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign reg_off  = DataAdr[3:2];
    assign bus_wr   = MemWrite & sel;
    assign stat_wr  = bus_wr & (reg_off == OFF_STAT);
    assign cyc_wr   = bus_wr & (reg_off == OFF_CYC);
    assign ctrl_wr  = bus_wr & (reg_off == OFF_CTRL);

    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);

    // Stream outputs depend only on registered state, never on tx_ready.
    assign tx_valid = en & ~fifo_empty;
    assign tx_data  = fifo_empty ? 32'h0 : mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign pop      = tx_valid & tx_ready;
    assign push_req = bus_wr & (reg_off == OFF_DATA);
    assign push     = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;

    assign count8   = 8'(count);

    // FIFO storage write; the array itself needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= WriteData;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Next-state for drain enable and the sticky overflow flag; a new drop beats a same-cycle clear.
    always_comb begin
        en_d  = en;
        ovf_d = ovf;
        if (ctrl_wr) begin
            en_d = WriteData[0];
        end
        if (stat_wr && WriteData[2]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Control/status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            en  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            en  <= en_d;
            ovf <= ovf_d;
        end
    end

    // Free-running cycle counter; a store to CYCLE restarts it from zero.
    always_ff @(posedge clk) begin
        if (reset || cyc_wr) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

`ifdef MMIO_IRQ_EN
    logic ie_d;
    logic irqf_d;
    logic drain_done;
    logic irq_q;

    // The FIFO goes empty through a pop only when the last word leaves and nothing replaces it.
    assign drain_done = pop & (count == CW'(1)) & ~push;

    // Next-state for irq enable and the drain-complete flag; setting beats a same-cycle clear.
    always_comb begin
        ie_d   = ie;
        irqf_d = irqf;
        if (ctrl_wr) begin
            ie_d = WriteData[1];
        end
        if (stat_wr && WriteData[3]) begin
            irqf_d = 1'b0;
        end
        if (drain_done) begin
            irqf_d = 1'b1;
        end
    end

    // Interrupt state; irq is a flop so the output is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie    <= 1'b0;
            irqf  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie    <= ie_d;
            irqf  <= irqf_d;
            irq_q <= irqf_d & ie_d;
        end
    end

    assign irq = irq_q;
`else
    assign ie   = 1'b0;
    assign irqf = 1'b0;
`endif

    // Zero-latency register read mux; reads show the state before the coming edge.
    always_comb begin
        rd_word = '0;
        case (reg_off)
            OFF_DATA: rd_word = tx_data;
            OFF_STAT: rd_word = {8'h00, count8, 12'h000, irqf, ovf, fifo_empty, fifo_full};
            OFF_CYC:  rd_word = cycle_q;
            default:  rd_word = {30'h0, ie, en};
        endcase
        ReadData = sel ? rd_word : 32'h0;
    end

endmodule

// File: tb/tb_mmio_tx_responder.sv
// tb_mmio_tx_responder: directed scenarios plus randomized bus/stream traffic against a queue-based model.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled 5 units after the edge.
// Backpressure: tx_ready is driven directly by the bench, randomly in the soak phase.
module tb_mmio_tx_responder;

    localparam logic [31:0] BASE   = 32'h0000_0080;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CYC  = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;
`ifdef MMIO_IRQ_EN
    localparam logic [31:0] IRQF_BIT = 32'h0000_0008;
`else
    localparam logic [31:0] IRQF_BIT = 32'h0000_0000;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] DataAdr   = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        tx_ready  = 1'b0;
    logic [31:0] ReadData;
    logic        sel;
    logic [31:0] tx_data;
    logic        tx_valid;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    mmio_tx_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .sel       (sel),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
`ifdef MMIO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a word queue plus flag bits and a cycle count.
    logic [31:0] q[$];
    bit          m_en;
    bit          m_ie;
    bit          m_ovf;
    bit          m_irqf;
    bit          m_irq;
    logic [31:0] m_cyc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_head();
        if (q.size() > 0) return q[0];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = 32'h0;
        s[0]     = (q.size() == DEPTH);
        s[1]     = (q.size() == 0);
        s[2]     = m_ovf;
        s[3]     = m_irqf;
        s[23:16] = 8'(q.size());
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] adr);
        if ((adr >> 4) != (BASE >> 4)) return 32'h0;
        case (adr[3:2])
            2'd0:    return m_head();
            2'd1:    return m_status();
            2'd2:    return m_cyc;
            default: return {30'h0, m_ie, m_en};
        endcase
    endfunction

    // Apply bus/stream inputs and move to the sampling point of this cycle.
    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic rdy);
        MemWrite  = we;
        DataAdr   = adr;
        WriteData = wd;
        tx_ready  = rdy;
        #4;
    endtask

    // Compare all outputs with the model, then advance the model and the clock by one cycle.
    task automatic advance();
        logic       exp_sel;
        logic       exp_vld;
        logic       hit;
        logic       pop;
        logic       dropped;
        logic [1:0] off;
        exp_sel = ((DataAdr >> 4) == (BASE >> 4));
        exp_vld = m_en && (q.size() > 0);
        chk("sel", 32'(sel), 32'(exp_sel));
        chk("tx_valid", 32'(tx_valid), 32'(exp_vld));
        chk("tx_data", tx_data, m_head());
        chk("ReadData", ReadData, m_read(DataAdr));
`ifdef MMIO_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
        if (reset) begin
            q.delete();
            m_en   = 1'b0;
            m_ie   = 1'b0;
            m_ovf  = 1'b0;
            m_irqf = 1'b0;
            m_irq  = 1'b0;
            m_cyc  = 32'h0;
        end else begin
            hit     = MemWrite && exp_sel;
            off     = DataAdr[3:2];
            pop     = exp_vld && tx_ready;
            dropped = 1'b0;
            if (pop) void'(q.pop_front());
            if (hit && off == 2'd0) begin
                if (q.size() < DEPTH) q.push_back(WriteData);
                else dropped = 1'b1;
            end
            if (hit && off == 2'd1 && WriteData[2]) m_ovf = 1'b0;
            if (dropped) m_ovf = 1'b1;
`ifdef MMIO_IRQ_EN
            if (hit && off == 2'd1 && WriteData[3]) m_irqf = 1'b0;
            if (pop && q.size() == 0) m_irqf = 1'b1;
            if (hit && off == 2'd3) m_ie = WriteData[1];
`endif
            if (hit && off == 2'd3) m_en = WriteData[0];
            m_cyc = (hit && off == 2'd2) ? 32'h0 : m_cyc + 32'd1;
            m_irq = m_irqf && m_ie;
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d[5];
    logic [31:0] e[4];

    initial begin
        m_en = 1'b0; m_ie = 1'b0; m_ovf = 1'b0; m_irqf = 1'b0; m_irq = 1'b0; m_cyc = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        drive(1'b0, A_CYC, 32'h0, 1'b0);
        chk("rst_cycle", ReadData, 32'h0);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        advance();
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("rst_status", ReadData, 32'h0000_0002);
        advance();

        // Three words held with drain disabled
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, A_DATA, 32'hA + 32'(i), 1'b0);
            advance();
        end
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("status_cnt3", ReadData, 32'h0003_0000);
        chk("hold_valid", 32'(tx_valid), 32'h0);
        advance();

        // Enable the drain and watch A, B, C leave back to back
        drive(1'b1, A_CTRL, 32'h1, 1'b1);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, A_DATA, 32'h0, 1'b1);
            chk("drain_valid", 32'(tx_valid), 32'h1);
            chk("drain_data", tx_data, 32'hA + 32'(i));
            advance();
        end
        drive(1'b0, A_STAT, 32'h0, 1'b1);
        chk("drained_status", ReadData, 32'h0000_0002 | IRQF_BIT);
        advance();
        drive(1'b1, A_STAT, 32'h8, 1'b0);
        advance();

        // Overflow: five pushes into four slots with no drain
        drive(1'b1, A_CTRL, 32'h0, 1'b0);
        advance();
        for (int i = 0; i < 5; i++) begin
            d[i] = $urandom;
            drive(1'b1, A_DATA, d[i], 1'b0);
            advance();
        end
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("ovf_status", ReadData, 32'h0004_0005);
        advance();
        drive(1'b1, A_STAT, 32'h4, 1'b0);
        advance();
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("ovf_cleared", ReadData, 32'h0004_0001);
        advance();

        // Push into a full FIFO while a pop happens in the same cycle
        drive(1'b1, A_CTRL, 32'h1, 1'b0);
        advance();
        drive(1'b1, A_DATA, 32'hE, 1'b1);
        chk("pp_head", tx_data, d[0]);
        chk("pp_valid", 32'(tx_valid), 32'h1);
        advance();
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("pp_status", ReadData, 32'h0004_0001);
        advance();
        e = '{d[1], d[2], d[3], 32'hE};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, A_DATA, 32'h0, 1'b1);
            chk("pp_order", tx_data, e[i]);
            advance();
        end
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("pp_empty", ReadData, 32'h0000_0002 | IRQF_BIT);
        advance();
        drive(1'b1, A_STAT, 32'h8, 1'b0);
        advance();

        // Reset aborts a pending drain and ignores a same-cycle store
        drive(1'b1, A_DATA, 32'h11, 1'b0);
        advance();
        drive(1'b1, A_DATA, 32'h22, 1'b0);
        advance();
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("pend_valid", 32'(tx_valid), 32'h1);
        advance();
        reset = 1'b1;
        drive(1'b1, A_DATA, 32'h33, 1'b0);
        advance();
        reset = 1'b0;
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("flush_status", ReadData, 32'h0000_0002);
        chk("flush_valid", 32'(tx_valid), 32'h0);
        advance();

        // CYCLE restart and wrap
        drive(1'b1, A_CYC, 32'h1234, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, A_CYC, 32'h0, 1'b0);
            chk("cycle_restart", ReadData, 32'(i));
            advance();
        end
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFF;
        drive(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycle_max", ReadData, 32'hFFFF_FFFF);
        advance();
        drive(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycle_wrap", ReadData, 32'h0);
        advance();

`ifdef MMIO_IRQ_EN
        // Interrupt on drain-to-empty, cleared by W1C
        drive(1'b1, A_CTRL, 32'h3, 1'b0);
        advance();
        drive(1'b1, A_DATA, 32'h55, 1'b1);
        advance();
        drive(1'b0, A_STAT, 32'h0, 1'b1);
        chk("irq_pop_valid", 32'(tx_valid), 32'h1);
        advance();
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("irq_set", 32'(irq), 32'h1);
        advance();
        drive(1'b1, A_STAT, 32'h8, 1'b0);
        advance();
        drive(1'b0, A_STAT, 32'h0, 1'b0);
        chk("irq_clear", 32'(irq), 32'h0);
        advance();
`endif

        // Randomized soak against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] adr;
            logic [1:0]  off;
            logic        we;
            logic        rdy;
            off = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 7) adr = $urandom;
            else adr = BASE + {28'h0, off, 2'($urandom_range(0, 3))};
            we    = ($urandom_range(0, 1) == 1);
            rdy   = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 199) == 0);
            drive(we, adr, $urandom, rdy);
            advance();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
